// File: rtl/awg_cmd_parser.sv
// UART command parser for the AWG: SYNC/CMD/D_HI/D_LO[/CHK] packets into config registers.
// Optional checksum byte is compiled in with AWG_CMD_CHECKSUM_EN.
module awg_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_data,
    input  logic        data_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DHI,
        GET_DLO
`ifdef AWG_CMD_CHECKSUM_EN
        , GET_CHK
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    cmd;
    logic [7:0]    dhi;
    logic          last;
    logic [7:0]    fin_lo;
    logic          chk_ok;
    logic          cmd_known;

`ifdef AWG_CMD_CHECKSUM_EN
    logic [7:0] dlo;

    always_comb begin
        last   = (state == GET_CHK);
        fin_lo = dlo;
        chk_ok = ((cmd ^ dhi ^ dlo) == uart_data);
    end
`else
    always_comb begin
        last   = (state == GET_DLO);
        fin_lo = uart_data;
        chk_ok = 1'b1;
    end
`endif

    assign cmd_known = (cmd >= 8'h01) && (cmd <= 8'h04);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd           <= '0;
            dhi           <= '0;
`ifdef AWG_CMD_CHECKSUM_EN
            dlo           <= '0;
`endif
            waveform_type <= 2'b00;
            frequency     <= 16'h0100;
            amplitude     <= 10'h3FF;
            dc_offset     <= 10'h200;
            cfg_update    <= 1'b0;
            err           <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            err        <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (data_valid && uart_data == SYNC)
                    state <= GET_CMD;
            end else if (data_valid) begin
                // A byte landing on the timeout cycle still wins.
                cnt <= '0;
                if (last) begin
                    state <= IDLE;
                    if (chk_ok && cmd_known) begin
                        cfg_update <= 1'b1;
                        case (cmd[2:0])
                            3'd1:    waveform_type <= fin_lo[1:0];
                            3'd2:    frequency     <= {dhi, fin_lo};
                            3'd3:    amplitude     <= {dhi[1:0], fin_lo};
                            3'd4:    dc_offset     <= {dhi[1:0], fin_lo};
                            default: ;
                        endcase
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    case (state)
                        GET_CMD: begin
                            cmd   <= uart_data;
                            state <= GET_DHI;
                        end
                        GET_DHI: begin
                            dhi   <= uart_data;
                            state <= GET_DLO;
                        end
`ifdef AWG_CMD_CHECKSUM_EN
                        GET_DLO: begin
                            dlo   <= uart_data;
                            state <= GET_CHK;
                        end
`endif
                        default: state <= IDLE;
                    endcase
                end
            end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                state <= IDLE;
                cnt   <= '0;
                err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
